// File: rtl/matmul_sequencer.sv
// matmul_sequencer
//   Once both N x N matrices sit in the loader, walks every output element
//   C[i][j] in row-major order. For each element it requests A row i and
//   B column j, waits READ_LATENCY cycles, registers the N element products,
//   reduces them with an adder tree and offers C[i][j] on a valid/ready stream.
//
// Ports
//   inter_refclk     in   sole clock, rising edge
//   rst              in   synchronous reset, active-high
//   start            in   begin a full multiply (ignored while busy)
//   a_row_in         in   A row at requested_a_row, element k = [k*ELEM_W +: ELEM_W]
//   b_col_in         in   B column at requested_b_col, same packing
//   requested_a_row  out  registered A row index to the loader
//   requested_b_col  out  registered B column index to the loader
//   c_valid          out  c_data/c_row/c_col hold a result
//   c_ready          in   consumer accepts the result while c_valid is high
//   c_data           out  C[c_row][c_col], unsigned
//   c_row            out  row index of c_data
//   c_col            out  column index of c_data
//   busy             out  high in every state except IDLE
//   done             out  one-cycle pulse after the last element is accepted
module matmul_sequencer #(
  parameter int unsigned N            = 32,
  parameter int unsigned ELEM_W       = 8,
  parameter int unsigned READ_LATENCY = 2,
  localparam int unsigned ADDR_W      = $clog2(N),
  localparam int unsigned ACC_W       = 2 * ELEM_W + $clog2(N)
) (
  input  logic                  inter_refclk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N*ELEM_W-1:0]   a_row_in,
  input  logic [N*ELEM_W-1:0]   b_col_in,
  output logic [ADDR_W-1:0]     requested_a_row,
  output logic [ADDR_W-1:0]     requested_b_col,
  output logic                  c_valid,
  input  logic                  c_ready,
  output logic [ACC_W-1:0]      c_data,
  output logic [ADDR_W-1:0]     c_row,
  output logic [ADDR_W-1:0]     c_col,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned PROD_W = 2 * ELEM_W;
  localparam int unsigned WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SUM,
    S_OUT
  } state_t;

  state_t                r_state;
  state_t                w_next;

  // r_i/r_j double as the registered address outputs
  logic [ADDR_W-1:0]     r_i;
  logic [ADDR_W-1:0]     r_j;
  logic [WAIT_W-1:0]     r_wait;
  logic [PROD_W-1:0]     r_prod [N];
  logic [ACC_W-1:0]      r_c_data;
  logic [ADDR_W-1:0]     r_c_row;
  logic [ADDR_W-1:0]     r_c_col;
  logic                  r_c_valid;
  logic                  r_done;

  logic                  w_start_run;
  logic                  w_capture;
  logic                  w_load_out;
  logic                  w_accept;
  logic                  w_last_elem;
  logic [ACC_W-1:0]      w_sum;

  // Next-state and control strobes
  always_comb begin
    w_next      = r_state;
    w_start_run = 1'b0;
    w_capture   = 1'b0;
    w_load_out  = 1'b0;
    w_accept    = 1'b0;
    w_last_elem = (r_i == LAST_IDX) && (r_j == LAST_IDX);
    case (r_state)
      S_IDLE: begin
        // a start coinciding with the done pulse is dropped
        if (start && !r_done) begin
          w_start_run = 1'b1;
          w_next      = S_FETCH;
        end
      end
      S_FETCH: begin
        if (r_wait == WAIT_LAST) begin
          w_capture = 1'b1;
          w_next    = S_SUM;
        end
      end
      S_SUM: begin
        w_load_out = 1'b1;
        w_next     = S_OUT;
      end
      S_OUT: begin
        // c_valid is high throughout OUT, so c_ready alone completes the handshake
        if (c_ready) begin
          w_accept = 1'b1;
          w_next   = w_last_elem ? S_IDLE : S_FETCH;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge inter_refclk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Reduction of the registered products; synthesis balances the chain into a tree
  always_comb begin
    w_sum = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_sum = w_sum + ACC_W'(r_prod[k]);
    end
  end

  always_ff @(posedge inter_refclk) begin
    if (rst) begin
      r_i       <= '0;
      r_j       <= '0;
      r_wait    <= '0;
      r_c_data  <= '0;
      r_c_row   <= '0;
      r_c_col   <= '0;
      r_c_valid <= 1'b0;
      r_done    <= 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
        r_prod[k] <= '0;
      end
    end else begin
      r_done <= 1'b0;

      if (w_start_run) begin
        r_i    <= '0;
        r_j    <= '0;
        r_wait <= '0;
      end

      if (r_state == S_FETCH) begin
        r_wait <= r_wait + 1'b1;
      end

      if (w_capture) begin
        for (int unsigned k = 0; k < N; k++) begin
          r_prod[k] <= PROD_W'(a_row_in[k*ELEM_W +: ELEM_W])
                     * PROD_W'(b_col_in[k*ELEM_W +: ELEM_W]);
        end
      end

      if (w_load_out) begin
        r_c_data  <= w_sum;
        r_c_row   <= r_i;
        r_c_col   <= r_j;
        r_c_valid <= 1'b1;
      end

      if (w_accept) begin
        r_c_valid <= 1'b0;
        r_wait    <= '0;
        if (w_last_elem) begin
          r_done <= 1'b1;
        end else if (r_j == LAST_IDX) begin
          r_j <= '0;
          r_i <= r_i + 1'b1;
        end else begin
          r_j <= r_j + 1'b1;
        end
      end
    end
  end

  assign requested_a_row = r_i;
  assign requested_b_col = r_j;
  assign c_valid         = r_c_valid;
  assign c_data          = r_c_data;
  assign c_row           = r_c_row;
  assign c_col           = r_c_col;
  assign busy            = (r_state != S_IDLE);
  assign done            = r_done;

endmodule
